// File: rtl/instr_sequencer_pkg.sv
// seq_pkg: shared state encoding, instruction constants and opcode field helper for instr_sequencer.
package seq_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0;
    localparam logic [5:0]  HALT_OP_DEF = 6'h3F;
    localparam int          OP_MSB      = 31;
    localparam int          OP_LSB      = 26;

    function automatic logic [5:0] opcode(input logic [31:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/instr_sequencer_timer.sv
// seq_timer: loadable down-counter; term is high while the count sits at zero.
module seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         term
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign term = cnt_q == '0;

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches words over req/ack, holds each on the datapath bus for EXEC_CYCLES,
// counts retirements and stops on halt opcode, fetch timeout or PC wrap.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter int          EXEC_CYCLES = 1,
    parameter int          TIMEOUT     = 16,
    parameter logic [5:0]  HALT_OP     = HALT_OP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              zero_flag,
    output logic              zf_last,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       retired,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int EW = 4;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       retired_q, retired_d;
    logic [31:0]       instr_q, instr_d;
    logic              zf_q, zf_d, err_q, err_d, valid_q, valid_d, req_q, req_d;
    logic              fetch_term, exec_term;

    // Both timers preload whenever their state is inactive, so they are armed on entry.
    seq_timer #(.W(TW)) u_fetch_timer (
        .clk(clk), .rst(rst), .load(state_q != FETCH), .en(state_q == FETCH),
        .load_val(TW'(TIMEOUT - 1)), .term(fetch_term)
    );

    seq_timer #(.W(EW)) u_exec_timer (
        .clk(clk), .rst(rst), .load(state_q != EXEC), .en(state_q == EXEC),
        .load_val(EW'(EXEC_CYCLES - 1)), .term(exec_term)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        zf_d      = zf_q;
        err_d     = err_q;
        case (state_q)
            IDLE, HALT: if (start) begin
                state_d   = FETCH;
                pc_d      = '0;
                retired_d = '0;
                err_d     = 1'b0;
                zf_d      = 1'b0;
            end
            FETCH: if (imem_ack) begin
                state_d = (opcode(imem_data) == HALT_OP) ? HALT : EXEC;
            end else if (fetch_term) begin
                err_d   = 1'b1;
                state_d = HALT;
            end
            EXEC: if (exec_term) begin
                zf_d      = zero_flag;
                retired_d = retired_q + 16'(retired_q != 16'hFFFF);
                err_d     = &pc_q;
                state_d   = (&pc_q) ? HALT : FETCH;
                pc_d      = (&pc_q) ? pc_q : pc_q + ADDR_W'(1);
            end
            default: state_d = IDLE;
        endcase
        req_d   = state_d == FETCH;
        valid_d = state_d == EXEC;
        instr_d = (state_d != EXEC) ? NOP_INSTR : (state_q == FETCH) ? imem_data : instr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            retired_q <= '0;
            zf_q      <= 1'b0;
            err_q     <= 1'b0;
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            zf_q      <= zf_d;
            err_q     <= err_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            req_q     <= req_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign zf_last     = zf_q;
    assign retired     = retired_q;
    assign busy        = state_q == FETCH || state_q == EXEC;
    assign done        = state_q == HALT;
    assign err         = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed runs against a per-cycle expected-output schedule built from the program.
module tb_instr_sequencer;

    localparam int AW = 2;
    localparam int EC = 2;
    localparam int TO = 6;

    logic          clk = 0, rst = 1, start = 0, imem_ack = 0, zero_flag = 0;
    logic [31:0]   imem_data = 0;
    logic          imem_req, instr_valid, zf_last, busy, done, err;
    logic [AW-1:0] imem_addr, pc;
    logic [31:0]   instr;
    logic [15:0]   retired;

    instr_sequencer #(.ADDR_W(AW), .EXEC_CYCLES(EC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid),
        .zero_flag(zero_flag), .zf_last(zf_last), .pc(pc), .retired(retired),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic        req;
        logic [1:0]  addr;
        logic        valid;
        logic [31:0] instr;
        logic        zf;
        logic [15:0] ret;
        logic [1:0]  pc;
        logic        busy;
        logic        done;
        logic        err;
    } obs_t;

    obs_t        q[$];
    obs_t        hold = '0;
    obs_t        act;
    logic [31:0] mem [4];
    int          lat = 1, reqcnt = 0, reqtot = 0, errs = 0, checks = 0, n0 = 0;
    bit          chk_en = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic obs_t rec(input logic r, input logic [1:0] p, input logic v, input logic [31:0] w,
                                 input logic z, input logic [15:0] n, input logic b, input logic d, input logic e);
        return '{req: r, addr: p, valid: v, instr: w, zf: z, ret: n, pc: p, busy: b, done: d, err: e};
    endfunction

    // Expected per-cycle outputs of one run, starting the cycle after start is taken.
    task automatic build();
        logic [1:0]  p = 0;
        logic [15:0] r = 0;
        logic        z = 0;
        logic [31:0] w;
        for (int k = 0; k < 8; k++) begin
            if (lat == 0) begin
                repeat (TO) q.push_back(rec(1, p, 0, 0, z, r, 1, 0, 0));
                q.push_back(rec(0, p, 0, 0, z, r, 0, 1, 1));
                return;
            end
            repeat (lat) q.push_back(rec(1, p, 0, 0, z, r, 1, 0, 0));
            w = mem[p];
            if (w[31:26] == 6'h3F) begin
                q.push_back(rec(0, p, 0, 0, z, r, 0, 1, 0));
                return;
            end
            repeat (EC) q.push_back(rec(0, p, 1, w, z, r, 1, 0, 0));
            r++;
            z = w[0];
            if (p == 2'd3) begin
                q.push_back(rec(0, p, 0, 0, z, r, 0, 1, 1));
                return;
            end
            p++;
        end
    endtask

    // Compare, then act as memory and datapath for the coming edge.
    always @(negedge clk) begin
        if (chk_en) begin
            if (q.size() > 0) hold = q.pop_front();
            act = {imem_req, imem_addr, instr_valid, instr, zf_last, retired, pc, busy, done, err};
            chk("cycle", 64'(act), 64'(hold));
        end
        if (imem_req) begin
            reqtot++;
            imem_ack = lat != 0 && reqcnt + 1 == lat;
            reqcnt   = imem_ack ? 0 : reqcnt + 1;
        end else begin
            imem_ack = 0;
            reqcnt   = 0;
        end
        imem_data = imem_ack ? mem[imem_addr] : 32'hDEADBEEF;
        zero_flag = instr_valid & instr[0];
    end

    task automatic do_start(input int l);
        lat = l;
        n0  = reqtot;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        build();
    endtask

    task automatic wait_q();
        for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
        chk("run_bound", 64'(q.size()), 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic s);
        @(posedge clk); #1 rst = 1; start = s;
        @(posedge clk); #1 rst = 0; start = 0;
        q.delete();
        hold = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        mem = '{32'h0123_4567, 32'h0AB0_CDE2, 32'h1111_1113, 32'hFC00_0000};
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;
        @(posedge clk); #2;
        chk("reset_busy", 64'(busy), 0);
        chk("reset_done", 64'(done), 0);

        do_start(1);
        wait_q();
        chk("t1_retired", 64'(retired), 3);
        chk("t1_pc", 64'(pc), 3);
        chk("t1_done_err", 64'({done, err}), 64'b10);
        chk("t1_zf", 64'(zf_last), 1);
        chk("t1_reqs", 64'(reqtot - n0), 4);

        do_start(5);
        wait_q();
        chk("t2_reqs", 64'(reqtot - n0), 20);
        chk("t2_retired", 64'(retired), 3);

        do_start(0);
        wait_q();
        chk("t3_reqs", 64'(reqtot - n0), TO);
        chk("t3_done_err", 64'({done, err}), 64'b11);
        chk("t3_retired", 64'(retired), 0);

        mem[1] = 32'hFC00_0001;
        do_start(TO);
        wait_q();
        chk("tb_reqs", 64'(reqtot - n0), 2 * TO);
        chk("tb_retired", 64'(retired), 1);
        chk("tb_err", 64'(err), 0);

        mem = '{32'h0000_0021, 32'h0000_0022, 32'hFC00_0000, 32'h0};
        do_start(1);
        for (int i = 0; i < 50 && retired != 1; i++) begin
            @(posedge clk); #2;
        end
        chk("t5_zf_first", 64'(zf_last), 1);
        wait_q();
        chk("t5_zf_second", 64'(zf_last), 0);
        chk("t5_retired", 64'(retired), 2);

        mem = '{32'h0000_0005, 32'h0000_0006, 32'h0000_0007, 32'h0000_0009};
        do_start(1);
        wait_q();
        chk("t4_retired", 64'(retired), 4);
        chk("t4_pc", 64'(pc), 3);
        chk("t4_err", 64'(err), 1);
        chk("t4_reqs", 64'(reqtot - n0), 4);

        mem = '{32'h0123_4567, 32'h0AB0_CDE2, 32'h1111_1113, 32'hFC00_0000};
        do_start(1);
        for (int i = 0; i < 50 && !(instr_valid && pc == 2'd1); i++) @(negedge clk);
        chk("t6_in_exec2", 64'({instr_valid, pc}), 64'b101);
        do_reset(0);
        #2;
        chk("t6_outs", 64'({imem_req, instr_valid, instr, busy, done, err}), 0);
        chk("t6_state", 64'({retired, pc, zf_last}), 0);

        do_reset(1);
        repeat (3) @(posedge clk);
        #2;
        chk("t7_busy_done", 64'({busy, done}), 0);

        do_start(3);
        repeat (2) @(posedge clk);
        #1 start = 1;
        @(posedge clk); #1 start = 0;
        wait_q();
        chk("t8_retired", 64'(retired), 3);
        chk("t8_reqs", 64'(reqtot - n0), 12);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
